cfg_routing_mux: RTL and testbench

Parametrised configurable routing multiplexer for the fabric's switch and connection blocks. Generalises the fixed 2:1 select mux to N_IN inputs of WIDTH bits each. The select code and an output-invert mode come from a serial configuration chain with a shadow/active register pair, so routing can be reloaded without glitching the live path. An optional output register gives a pipelined routing stage.

---
 rtl/fabric_cfg_pkg.sv | 30 +++
 rtl/cfg_chain_ff.sv | 75 +++++++
 rtl/cfg_routing_mux.sv | 81 ++++++++
 tb/tb_cfg_routing_mux.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fabric_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fabric_cfg_pkg
// Brief    : Width helpers shared by configurable fabric blocks.
// Revision : 1.0 - initial release
// ============================================================================
package fabric_cfg_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int sel_width(input int n_in);
        return (clog2(n_in) < 1) ? 1 : clog2(n_in);
    endfunction

    function automatic int chain_width(input int n_in);
        return sel_width(n_in) + 1;
    endfunction

    // The invert bit sits directly above the select code, i.e. at the chain MSB.
    function automatic int inv_bit_pos(input int n_in);
        return sel_width(n_in);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_chain_ff.sv
`default_nettype none
// ============================================================================
// Module   : cfg_chain_ff
// Brief    : Serial shadow config chain with frame tracking and active copy.
// Revision : 1.0 - initial release
// ============================================================================
module cfg_chain_ff
    import fabric_cfg_pkg::*;
#(
    parameter int CHAIN_W    = 3,
    parameter int CODE_W     = CHAIN_W - 1,
    parameter int CODE_LIMIT = 1 << CODE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_head,
    input  logic               i_shift_en,
    input  logic               i_commit,
    output logic               o_tail,
    output logic [CHAIN_W-1:0] o_active,
    output logic               o_valid,
    output logic               o_err
);

    localparam int c_CNT_W = (clog2(CHAIN_W) < 1) ? 1 : clog2(CHAIN_W);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CHAIN_W - 1);

    logic [CHAIN_W-1:0] r_sh;
    logic [CHAIN_W-1:0] r_active;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_dirty;
    logic               r_valid;
    logic               r_err;
    logic               w_frame_ok;
    logic               w_code_err;

    // Frame is whole when something was shifted and the counter has wrapped.
    assign w_frame_ok = r_dirty && (r_cnt == '0);
    assign w_code_err = (32'(r_sh[CODE_W-1:0]) >= CODE_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh     <= '0;
            r_cnt    <= '0;
            r_dirty  <= 1'b0;
            r_active <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (i_commit) begin
                if (w_frame_ok) begin
                    r_active <= r_sh;
                    r_valid  <= 1'b1;
                    r_err    <= w_code_err;
                    r_dirty  <= 1'b0;
                end else begin
                    r_err    <= 1'b1;
                end
            end
            // Shift after commit so a same-cycle shift re-dirties the chain.
            if (i_shift_en) begin
                r_sh    <= {r_sh[CHAIN_W-2:0], i_head};
                r_cnt   <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + 1'b1;
                r_dirty <= 1'b1;
            end
        end
    end

    assign o_tail   = r_sh[CHAIN_W-1];
    assign o_active = r_active;
    assign o_valid  = r_valid;
    assign o_err    = r_err;

endmodule
`default_nettype wire

// File: rtl/cfg_routing_mux.sv
`default_nettype none
// ============================================================================
// Module   : cfg_routing_mux
// Brief    : N_IN:1 configurable routing mux with invert and optional register.
// Revision : 1.0 - initial release
// ============================================================================
module cfg_routing_mux
    import fabric_cfg_pkg::*;
#(
    parameter int N_IN    = 4,
    parameter int WIDTH   = 1,
    parameter int REG_OUT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ccff_head,
    input  logic                  ccff_en,
    input  logic                  cfg_commit,
    output logic                  ccff_tail,
    input  logic [N_IN*WIDTH-1:0] din,
    output logic [WIDTH-1:0]      dout,
    output logic                  cfg_valid,
    output logic                  cfg_err
);

    localparam int c_SEL_W   = sel_width(N_IN);
    localparam int c_CHAIN_W = chain_width(N_IN);
    localparam int c_INV_POS = inv_bit_pos(N_IN);

    logic [c_CHAIN_W-1:0] w_active;
    logic [c_SEL_W-1:0]   w_sel;
    logic                 w_inv;
    logic                 w_in_range;
    logic [WIDTH-1:0]     w_mux_out;
    logic [WIDTH-1:0]     w_dout_next;

    cfg_chain_ff #(
        .CHAIN_W    (c_CHAIN_W),
        .CODE_W     (c_SEL_W),
        .CODE_LIMIT (N_IN)
    ) u_chain (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_head     (ccff_head),
        .i_shift_en (ccff_en),
        .i_commit   (cfg_commit),
        .o_tail     (ccff_tail),
        .o_active   (w_active),
        .o_valid    (cfg_valid),
        .o_err      (cfg_err)
    );

    assign w_sel      = w_active[c_SEL_W-1:0];
    assign w_inv      = w_active[c_INV_POS];
    assign w_in_range = (32'(w_sel) < N_IN);

    always_comb begin
        w_mux_out = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (w_sel == c_SEL_W'(i)) w_mux_out = din[i*WIDTH +: WIDTH];
        end
    end

    // Out-of-range codes force a plain zero, never an inverted one.
    assign w_dout_next = (cfg_valid && w_in_range) ? (w_mux_out ^ {WIDTH{w_inv}}) : '0;

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [WIDTH-1:0] r_dout;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_dout <= '0;
                else        r_dout <= w_dout_next;
            end
            assign dout = r_dout;
        end else begin : g_comb_out
            assign dout = w_dout_next;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cfg_routing_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfg_routing_mux
// Brief    : Randomized and directed bench for cfg_routing_mux against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cfg_routing_mux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ccff_head = 1'b0;
    logic        ccff_en = 1'b0;
    logic        cfg_commit = 1'b0;
    logic [31:0] din = 32'hFFFF_FFFF;

    logic [7:0] dout0, dout1, dout2;
    logic       tail0, tail1, tail2;
    logic       valid0, valid1, valid2;
    logic       err0, err1, err2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // dut0/dut1 share the head; dut2 is cascaded behind dut0 and has 3 inputs.
    cfg_routing_mux #(.N_IN(4), .WIDTH(8), .REG_OUT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ccff_head(ccff_head), .ccff_en(ccff_en),
        .cfg_commit(cfg_commit), .ccff_tail(tail0), .din(din), .dout(dout0),
        .cfg_valid(valid0), .cfg_err(err0));

    cfg_routing_mux #(.N_IN(4), .WIDTH(8), .REG_OUT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ccff_head(ccff_head), .ccff_en(ccff_en),
        .cfg_commit(cfg_commit), .ccff_tail(tail1), .din(din), .dout(dout1),
        .cfg_valid(valid1), .cfg_err(err1));

    cfg_routing_mux #(.N_IN(3), .WIDTH(8), .REG_OUT(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .ccff_head(tail0), .ccff_en(ccff_en),
        .cfg_commit(cfg_commit), .ccff_tail(tail2), .din(din[23:0]), .dout(dout2),
        .cfg_valid(valid2), .cfg_err(err2));

    // Model state: index 0 = 4-input chain, index 1 = cascaded 3-input chain.
    int   m_sh[2];
    int   m_act[2];
    int   m_pend[2];
    bit   m_valid[2];
    bit   m_err[2];
    logic [7:0] exp_reg1;
    bit   hist[$];

    function automatic int nin(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    function automatic logic [7:0] exp_dout(input int k);
        int sel, inv;
        logic [7:0] b;
        sel = m_act[k] % 4;
        inv = m_act[k] / 4;
        if (!m_valid[k] || sel >= nin(k)) return 8'h00;
        b = 8'((din >> (sel * 8)) & 32'hFF);
        return (inv != 0) ? ~b : b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_sh[k] = 0; m_act[k] = 0; m_pend[k] = 0;
            m_valid[k] = 0; m_err[k] = 0;
        end
        exp_reg1 = 8'h00;
        hist.delete();
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        check("dout0",  32'(dout0),  32'(exp_dout(0)));
        check("valid0", 32'(valid0), 32'(m_valid[0]));
        check("err0",   32'(err0),   32'(m_err[0]));
        check("tail0",  32'(tail0),  32'((m_sh[0] / 4) % 2));
        check("dout1",  32'(dout1),  32'(exp_reg1));
        check("valid1", 32'(valid1), 32'(m_valid[0]));
        check("err1",   32'(err1),   32'(m_err[0]));
        check("tail1",  32'(tail1),  32'((m_sh[0] / 4) % 2));
        check("dout2",  32'(dout2),  32'(exp_dout(1)));
        check("valid2", 32'(valid2), 32'(m_valid[1]));
        check("err2",   32'(err2),   32'(m_err[1]));
        check("tail2",  32'(tail2),  32'((m_sh[1] / 4) % 2));
        if (hist.size() >= 3) check("tail0_hist", 32'(tail0), 32'(hist[hist.size()-3]));
    endtask

    task automatic tick(input logic h, input logic en, input logic cm);
        logic [7:0] nx1;
        int b1;
        bit ok;
        ccff_head = h; ccff_en = en; cfg_commit = cm;
        @(posedge clk);
        nx1 = exp_dout(0);
        b1  = (m_sh[0] / 4) % 2;
        for (int k = 0; k < 2; k++) begin
            ok = (m_pend[k] > 0) && (m_pend[k] % 3 == 0);
            if (cm) begin
                if (ok) begin
                    m_act[k] = m_sh[k]; m_valid[k] = 1;
                    m_err[k] = ((m_sh[k] % 4) >= nin(k)); m_pend[k] = 0;
                end else begin
                    m_err[k] = 1;
                end
            end
            if (en) begin
                m_sh[k] = (m_sh[k] * 2 + ((k == 0) ? int'(h) : b1)) % 8;
                m_pend[k]++;
            end
        end
        if (en) hist.push_back(h);
        exp_reg1 = nx1;
        #1;
        ccff_en = 1'b0; cfg_commit = 1'b0;
        check_all();
    endtask

    task automatic shift_bits(input logic [5:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) tick(bits[i], 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        // Reset state with all-ones inputs.
        repeat (2) @(negedge clk);
        check("rst_dout0", 32'(dout0), 32'h00);
        check("rst_dout1", 32'(dout1), 32'h00);
        check("rst_valid", 32'(valid0), 32'h0);
        check("rst_err",   32'(err0), 32'h0);
        check("rst_tail",  32'(tail0), 32'h0);
        check_all();
        rst_n = 1'b1;

        // Select 2, no invert.
        din = 32'h44A5_2211;
        shift_bits(6'b000_010, 3);
        tick(1'b0, 1'b0, 1'b1);
        check("sel2_dout0", 32'(dout0), 32'hA5);
        check("sel2_valid", 32'(valid0), 32'h1);
        check("sel2_dout1_early", 32'(dout1), 32'h00);
        tick(1'b0, 1'b0, 1'b0);
        check("sel2_dout1", 32'(dout1), 32'hA5);

        // Select 1 inverted, then a short frame is rejected.
        din = 32'h44A5_0F11;
        shift_bits(6'b000_101, 3);
        tick(1'b0, 1'b0, 1'b1);
        check("inv_dout0", 32'(dout0), 32'hF0);
        shift_bits(6'b000_011, 2);
        tick(1'b0, 1'b0, 1'b1);
        check("short_err", 32'(err0), 32'h1);
        check("short_dout", 32'(dout0), 32'hF0);

        // Cascade: out-of-range code for the 3-input instance, then a valid one.
        do_reset();
        din = 32'hDEAD_BEEF;
        shift_bits(6'b011_000, 6);
        tick(1'b0, 1'b0, 1'b1);
        check("oor_err2",  32'(err2), 32'h1);
        check("oor_dout2", 32'(dout2), 32'h00);
        check("oor_err0",  32'(err0), 32'h0);
        shift_bits(6'b000_001, 6);
        tick(1'b0, 1'b0, 1'b1);
        check("fix_err2",  32'(err2), 32'h0);
        check("fix_dout2", 32'(dout2), 32'hEF);
        check("fix_dout0", 32'(dout0), 32'hBE);

        // Commit and shift in the same cycle, then an immediate commit.
        do_reset();
        shift_bits(6'b000_011, 3);
        tick(1'b1, 1'b1, 1'b1);
        check("same_dout0", 32'(dout0), 32'hDE);
        tick(1'b0, 1'b0, 1'b1);
        check("same_err", 32'(err0), 32'h1);
        check("same_keep", 32'(dout0), 32'hDE);

        // Reset mid-shift drops the partial frame.
        shift_bits(6'b000_011, 2);
        do_reset();
        check("mid_dout0", 32'(dout0), 32'h00);
        check("mid_valid", 32'(valid0), 32'h0);
        tick(1'b0, 1'b0, 1'b1);
        check("mid_reject", 32'(err0), 32'h1);
        shift_bits(6'b000_000, 3);
        tick(1'b0, 1'b0, 1'b1);
        check("mid_accept", 32'(valid0), 32'h1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            din = $urandom;
            if (i == 200) do_reset();
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 4) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
